// File: rtl/videomem_line_fetch_if.sv
// SDRAM read-port bundle between the line fetcher (master) and the SDRAM controller (slave).
`timescale 1ns/1ps
interface videomem_line_fetch_if;
  logic        rd_request;
  logic [24:0] rd_addr;
  logic        mem_req_ack;
  logic        rd_data_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_request, rd_addr,
    input  mem_req_ack, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_request, rd_addr,
    output mem_req_ack, rd_data_valid, rd_data
  );
endinterface

// File: rtl/videomem_line_fetch.sv
// Display line fetcher: issues 4-word SDRAM read bursts for one line and
// buffers the returned words in a first-word-fall-through pixel FIFO.
`timescale 1ns/1ps
module videomem_line_fetch #(
  parameter int unsigned NUM_HORZ_RD_REQ = 24,
  parameter int unsigned FIFO_AW         = 7
) (
  input  logic                 mem_clock,
  input  logic                 reset,
  input  logic                 init_complete,
  input  logic                 line_start,
  input  logic [12:0]          line_num,
  videomem_line_fetch_if.master mem,
  output logic [31:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_rd,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 busy,
  output logic                 line_done,
  output logic                 underflow,
  output logic                 proto_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_SPACE = 2'd1;
  localparam logic [1:0] S_REQ        = 2'd2;
  localparam logic [1:0] S_DATA       = 2'd3;

  localparam logic [9:0]         LAST_REQ    = 10'(NUM_HORZ_RD_REQ - 1);
  // A burst may only be requested when all 4 of its beats are guaranteed to fit.
  localparam logic [FIFO_AW:0]   SPACE_LIMIT = (FIFO_AW + 1)'(DEPTH - 4);

  logic [1:0]         state;
  logic [12:0]        nline;
  logic [9:0]         nreq;
  logic [1:0]         beat;
  logic               rd_req;

  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;

  assign push = (state == S_DATA) && mem.rd_data_valid;
  assign pop  = pix_rd && (count != '0);

  assign mem.rd_request = rd_req;
  assign mem.rd_addr    = {nline, nreq, 2'b00};
  assign pix_valid      = (count != '0);
  assign pix_data       = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign fifo_level     = count;
  assign busy           = (state != S_IDLE);

  // Fetch sequencing: line acceptance, space check, request handshake, beat counting.
  always_ff @(posedge mem_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      nline     <= '0;
      nreq      <= '0;
      beat      <= '0;
      rd_req    <= 1'b0;
      line_done <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if ((line_start && state != S_IDLE) || (mem.rd_data_valid && state != S_DATA))
        proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (line_start && init_complete) begin
            nline <= line_num;
            nreq  <= '0;
            state <= S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          if (count <= SPACE_LIMIT) begin
            rd_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_req_ack) begin
            rd_req <= 1'b0;
            beat   <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem.rd_data_valid) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              if (nreq == LAST_REQ) begin
                line_done <= 1'b1;
                state     <= S_IDLE;
              end else begin
                nreq  <= nreq + 10'd1;
                state <= S_WAIT_SPACE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and the sticky underflow flag.
  always_ff @(posedge mem_clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pix_rd && count == '0) underflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port; contents need no reset since pointers gate visibility.
  always_ff @(posedge mem_clock) begin
    if (push) fifo_mem[wr_ptr] <= mem.rd_data;
  end

endmodule

// File: tb/tb_videomem_line_fetch.sv
// Testbench for videomem_line_fetch: randomized SDRAM responder and pixel
// consumer checked against a queue-based model of lines, bursts and FIFO words.
`timescale 1ns/1ps
module tb_videomem_line_fetch;

  localparam int unsigned NREQ  = 24;
  localparam int unsigned AW    = 7;
  localparam int          DEPTH = 1 << AW;

  logic        mem_clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_complete = 1'b0;
  logic        line_start = 1'b0;
  logic [12:0] line_num = '0;
  logic        pix_rd = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic [AW:0] fifo_level;
  logic        busy, line_done, underflow, proto_err;

  videomem_line_fetch_if mem_bus ();

  videomem_line_fetch #(.NUM_HORZ_RD_REQ(NREQ), .FIFO_AW(AW)) dut (
    .mem_clock     (mem_clock),
    .reset         (reset),
    .init_complete (init_complete),
    .line_start    (line_start),
    .line_num      (line_num),
    .mem           (mem_bus.master),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_rd        (pix_rd),
    .fifo_level    (fifo_level),
    .busy          (busy),
    .line_done     (line_done),
    .underflow     (underflow),
    .proto_err     (proto_err)
  );

  always #5 mem_clock = ~mem_clock;

  int tests = 0;
  int fails = 0;

  // Agent policies
  int unsigned ack_delay = 1;
  int unsigned beat_prob = 100;
  int unsigned pop_prob  = 0;
  bit          pop_empty = 1'b0;

  // Reference model
  logic [31:0] exp_q[$];
  logic [24:0] addr_q[$];
  bit line_active = 1'b0;
  bit in_data = 1'b0;
  bit ld_pending = 1'b0;
  bit exp_proto = 1'b0;
  bit exp_under = 1'b0;
  int beats_left = 0;
  int req_seen = 0;
  bit prev_req = 1'b0;
  int acks = 0;
  int popped = 0;
  int line_dones = 0;
  int max_level = 0;

  // One clock: sample and check DUT against model, then drive next inputs and advance model.
  task automatic cycle(input bit start = 1'b0, input logic [12:0] lnum = '0, input bit do_rst = 1'b0);
    bit beat, pop, ack;
    logic [31:0] w;
    logic [AW:0] lvl_exp;
    @(posedge mem_clock); #1;
    lvl_exp = (AW + 1)'(exp_q.size());
    tests++;
    if (fifo_level !== lvl_exp) begin
      fails++; $display("FAIL fifo_level: got %0d expected %0d", fifo_level, lvl_exp);
    end
    tests++;
    if (pix_valid !== (exp_q.size() != 0)) begin
      fails++; $display("FAIL pix_valid: got %b expected %b", pix_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      tests++;
      if (pix_data !== exp_q[0]) begin
        fails++; $display("FAIL pix_data: got %h expected %h", pix_data, exp_q[0]);
      end
    end
    tests++;
    if ({busy, line_done, underflow, proto_err} !== {line_active, ld_pending, exp_under, exp_proto}) begin
      fails++;
      $display("FAIL status busy/line_done/underflow/proto_err: got %b%b%b%b expected %b%b%b%b",
               busy, line_done, underflow, proto_err, line_active, ld_pending, exp_under, exp_proto);
    end
    if (mem_bus.rd_request) begin
      tests++;
      if (addr_q.size() == 0 || in_data) begin
        fails++; $display("FAIL rd_request: got 1 expected 0 (no burst due)");
      end else if (mem_bus.rd_addr !== addr_q[0]) begin
        fails++; $display("FAIL rd_addr: got %h expected %h", mem_bus.rd_addr, addr_q[0]);
      end
      if (!prev_req) begin
        tests++;
        if (exp_q.size() > DEPTH - 4) begin
          fails++; $display("FAIL space_check: request with level %0d expected <= %0d", exp_q.size(), DEPTH - 4);
        end
      end
    end
    prev_req = mem_bus.rd_request;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (line_done === 1'b1) line_dones++;

    // drive
    ld_pending = 1'b0;
    ack = 1'b0;
    if (!do_rst && mem_bus.rd_request && addr_q.size() != 0 && !in_data) begin
      req_seen++;
      if (req_seen >= int'(ack_delay)) ack = 1'b1;
    end
    beat = !do_rst && beats_left > 0 && ($urandom_range(99) < beat_prob);
    pop  = !do_rst && ((exp_q.size() != 0 && $urandom_range(99) < pop_prob) || pop_empty);
    w = $urandom;
    reset = do_rst;
    line_start = start;
    line_num = lnum;
    pix_rd = pop;
    mem_bus.mem_req_ack = ack;
    mem_bus.rd_data_valid = beat;
    mem_bus.rd_data = w;

    // model advance for the coming edge
    if (do_rst) begin
      exp_q.delete(); addr_q.delete();
      line_active = 1'b0; in_data = 1'b0; exp_proto = 1'b0; exp_under = 1'b0; req_seen = 0;
    end else begin
      if (start) begin
        if (line_active) exp_proto = 1'b1;
        else if (init_complete) begin
          line_active = 1'b1;
          for (int k = 0; k < int'(NREQ); k++)
            addr_q.push_back(25'((int'(lnum) << 12) | (k << 2)));
        end
      end
      if (pop) begin
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); popped++; end
        else exp_under = 1'b1;
      end
      if (ack) begin
        void'(addr_q.pop_front());
        in_data = 1'b1; beats_left = 4; req_seen = 0; acks++;
      end
      if (beat) begin
        beats_left--;
        if (in_data) begin
          exp_q.push_back(w);
          if (beats_left == 0) begin
            in_data = 1'b0;
            if (addr_q.size() == 0) begin line_active = 1'b0; ld_pending = 1'b1; end
          end
        end else exp_proto = 1'b1;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((line_active || beats_left != 0) && n < budget) begin cycle(); n++; end
    tests++;
    if (line_active || beats_left != 0) begin
      fails++; $display("FAIL line_timeout: still busy after %0d cycles, required idle", budget);
    end
    cycle();
  endtask

  task automatic drain();
    int n = 0;
    int unsigned keep = pop_prob;
    pop_prob = 100;
    while (exp_q.size() != 0 && n < 400) begin cycle(); n++; end
    cycle();
    pop_prob = keep;
  endtask

  task automatic test_reset();
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle();
    tests++;
    if ({mem_bus.rd_request, mem_bus.rd_addr, pix_valid, fifo_level} !== '0) begin
      fails++; $display("FAIL reset_mem_outputs: got req=%b addr=%h valid=%b level=%0d expected all 0",
                        mem_bus.rd_request, mem_bus.rd_addr, pix_valid, fifo_level);
    end
    tests++;
    if ({pix_data, busy, line_done, underflow, proto_err} !== '0) begin
      fails++; $display("FAIL reset_status: got data=%h flags=%b%b%b%b expected all 0",
                        pix_data, busy, line_done, underflow, proto_err);
    end
  endtask

  task automatic test_single_line();
    int a0 = acks, d0 = line_dones, p0 = popped;
    init_complete = 1'b1;
    ack_delay = 2; beat_prob = 100; pop_prob = 40;
    cycle(1'b1, 13'd5);
    cycle();
    tests++;
    if (mem_bus.rd_request !== 1'b0) begin
      fails++; $display("FAIL t1_latency_early: rd_request got %b expected 0", mem_bus.rd_request);
    end
    cycle();
    tests++;
    if (mem_bus.rd_request !== 1'b1 || mem_bus.rd_addr !== 25'h0005000) begin
      fails++; $display("FAIL t1_first_request: got req=%b addr=%h expected 1 / 0005000",
                        mem_bus.rd_request, mem_bus.rd_addr);
    end
    run_until_idle(2000);
    drain();
    tests++;
    if (acks - a0 != 24 || line_dones - d0 != 1 || popped - p0 != 96) begin
      fails++; $display("FAIL t1_totals: got acks=%0d done=%0d words=%0d expected 24/1/96",
                        acks - a0, line_dones - d0, popped - p0);
    end
  endtask

  task automatic test_backpressure();
    int a0, n = 0, p0 = popped;
    ack_delay = 1; beat_prob = 70; pop_prob = 0;
    cycle(1'b1, 13'd100);
    run_until_idle(2000);
    a0 = acks;
    cycle(1'b1, 13'd8191);
    while (exp_q.size() < DEPTH && n < 500) begin cycle(); n++; end
    repeat (20) cycle();
    tests++;
    if (fifo_level !== 8'd128 || busy !== 1'b1 || mem_bus.rd_request !== 1'b0) begin
      fails++; $display("FAIL t2_stall: got level=%0d busy=%b req=%b expected 128/1/0",
                        fifo_level, busy, mem_bus.rd_request);
    end
    tests++;
    if (acks - a0 != 8) begin
      fails++; $display("FAIL t2_stall_reqs: got %0d bursts expected 8", acks - a0);
    end
    pop_prob = 25;
    run_until_idle(3000);
    drain();
    tests++;
    if (popped - p0 != 192 || line_dones < 3) begin
      fails++; $display("FAIL t2_words: got %0d words expected 192", popped - p0);
    end
  endtask

  task automatic test_stream();
    int p0 = popped;
    ack_delay = $urandom_range(4, 1); beat_prob = 60; pop_prob = 100;
    max_level = 0;
    cycle(1'b1, 13'd42);
    run_until_idle(3000);
    drain();
    tests++;
    if (max_level > 4 || underflow !== 1'b0 || popped - p0 != 96) begin
      fails++; $display("FAIL t3_stream: got max_level=%0d underflow=%b words=%0d expected <=4/0/96",
                        max_level, underflow, popped - p0);
    end
  endtask

  task automatic test_init_and_busy();
    int a0 = acks, p0;
    init_complete = 1'b0;
    cycle(1'b1, 13'd7);
    repeat (10) cycle();
    tests++;
    if (busy !== 1'b0 || proto_err !== 1'b0 || acks != a0) begin
      fails++; $display("FAIL t4_no_init: got busy=%b proto_err=%b bursts=%0d expected 0/0/0",
                        busy, proto_err, acks - a0);
    end
    init_complete = 1'b1;
    ack_delay = 3; beat_prob = 80; pop_prob = 50;
    p0 = popped;
    cycle(1'b1, 13'd3);
    repeat (30) cycle();
    cycle(1'b1, 13'd9);
    run_until_idle(3000);
    drain();
    tests++;
    if (proto_err !== 1'b1 || acks - a0 != 24 || popped - p0 != 96) begin
      fails++; $display("FAIL t4_busy_start: got proto_err=%b bursts=%0d words=%0d expected 1/24/96",
                        proto_err, acks - a0, popped - p0);
    end
  endtask

  task automatic test_underflow();
    pop_empty = 1'b1;
    cycle();
    pop_empty = 1'b0;
    cycle();
    tests++;
    if (underflow !== 1'b1 || fifo_level !== '0 || pix_valid !== 1'b0) begin
      fails++; $display("FAIL t6_underflow: got underflow=%b level=%0d valid=%b expected 1/0/0",
                        underflow, fifo_level, pix_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n = 0;
    ack_delay = 1; beat_prob = 100; pop_prob = 0;
    cycle(1'b1, 13'd20);
    while (!(in_data && beats_left == 2) && n < 100) begin cycle(); n++; end
    cycle(1'b0, '0, 1'b1);
    cycle();
    tests++;
    if ({mem_bus.rd_request, mem_bus.rd_addr, pix_data, pix_valid, fifo_level,
         busy, line_done, underflow, proto_err} !== '0) begin
      fails++; $display("FAIL t5_reset_outputs: got req=%b addr=%h level=%0d flags=%b%b%b%b expected all 0",
                        mem_bus.rd_request, mem_bus.rd_addr, fifo_level, busy, line_done, underflow, proto_err);
    end
    repeat (10) cycle();
    tests++;
    if (proto_err !== 1'b1 || fifo_level !== '0 || busy !== 1'b0 || beats_left != 0) begin
      fails++; $display("FAIL t5_stray_beats: got proto_err=%b level=%0d busy=%b expected 1/0/0",
                        proto_err, fifo_level, busy);
    end
  endtask

  initial begin
    mem_bus.mem_req_ack = 1'b0;
    mem_bus.rd_data_valid = 1'b0;
    mem_bus.rd_data = '0;
    test_reset();
    test_single_line();
    test_backpressure();
    test_stream();
    test_init_and_busy();
    test_underflow();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
